keccak_req_arbiter: RTL and testbench

//  Shares one keccak core between NREQ independent message sources using round-robin arbitration.

---
 rtl/keccak_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_keccak_req_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_req_arbiter.sv
// Round-robin front end that shares one keccak core between NREQ message sources.
// One requester owns the core per message; the core is cleared before every message.
module keccak_req_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    input  logic [2*NREQ-1:0]    req_byte_num,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [511:0]         digest,
    output logic                 busy,
    output logic                 core_reset,
    output logic [31:0]          core_in,
    output logic                 core_in_ready,
    output logic                 core_is_last,
    output logic [1:0]           core_byte_num,
    input  logic                 core_buf_full,
    input  logic [511:0]         core_out,
    input  logic                 core_out_ready,
    output logic [1:0]           dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g_idx;
    logic [IW-1:0]   rr_next;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            pick_found;
    logic            sel_valid;
    logic            sel_last;
    logic [31:0]     sel_data;
    logic [1:0]      sel_bn;
    logic            accept;

    // Handshake: a word moves from the owner into the core on a rising edge where
    // req_valid[g] & req_ready[g] is high; req_ready[g] mirrors core_in_ready and is
    // only ever asserted in FEED for the granted requester, so the requester must
    // hold its word (and last/byte_num) stable until that edge.

    // Two-pass scan: first requesters at or above rr_ptr, then wrap to the bottom.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i] && (IW'(i) >= rr_ptr)) begin
                pick_found     = 1'b1;
                pick_idx       = IW'(i);
                pick_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i]) begin
                pick_found     = 1'b1;
                pick_idx       = IW'(i);
                pick_onehot[i] = 1'b1;
            end
        end
    end

    // Owner's signals selected by the one-hot grant register.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_bn    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[32*i +: 32];
                sel_bn    = req_byte_num[2*i +: 2];
            end
        end
    end

    assign accept  = (state == S_FEED) && sel_valid && !core_buf_full;
    assign rr_next = (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + IW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found)           state_nxt = S_CLEAR;
            S_CLEAR:                           state_nxt = S_FEED;
            S_FEED:  if (accept && sel_last)   state_nxt = S_WAIT;
            S_WAIT:  if (core_out_ready)       state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // Requester-to-core path is combinational in FEED and parked at zero elsewhere.
    always_comb begin
        core_in       = '0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        core_in_ready = 1'b0;
        req_ready     = '0;
        if (state == S_FEED) begin
            core_in       = sel_data;
            core_is_last  = sel_last;
            core_byte_num = sel_bn;
            core_in_ready = sel_valid && !core_buf_full;
            req_ready     = grant & {NREQ{sel_valid && !core_buf_full}};
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // core_reset is high exactly while the FSM sits in CLEAR, and throughout arbiter reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            g_idx      <= '0;
            grant      <= '0;
            done       <= '0;
            digest     <= '0;
            core_reset <= 1'b1;
        end else begin
            done       <= '0;
            core_reset <= (state_nxt == S_CLEAR);
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant <= pick_onehot;
                        g_idx <= pick_idx;
                    end
                end
                S_WAIT: begin
                    if (core_out_ready) begin
                        digest <= core_out;
                        done   <= grant;
                        rr_ptr <= rr_next;
                        grant  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_req_arbiter.sv
// Bench for keccak_req_arbiter: requesters and a stand-in keccak core are modelled here,
// and a queue-based reference predicts owners, completion order and digests.
module tb_keccak_req_arbiter;

    localparam int NREQ = 2;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [2*NREQ-1:0]    req_byte_num;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [511:0]         digest;
    logic                 busy;
    logic                 core_reset;
    logic [31:0]          core_in;
    logic                 core_in_ready;
    logic                 core_is_last;
    logic [1:0]           core_byte_num;
    logic                 core_buf_full;
    logic [511:0]         core_out;
    logic                 core_out_ready;
    logic [1:0]           dbg_state;

    keccak_req_arbiter #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_byte_num   (req_byte_num),
        .req_ready      (req_ready),
        .grant          (grant),
        .done           (done),
        .digest         (digest),
        .busy           (busy),
        .core_reset     (core_reset),
        .core_in        (core_in),
        .core_in_ready  (core_in_ready),
        .core_is_last   (core_is_last),
        .core_byte_num  (core_byte_num),
        .core_buf_full  (core_buf_full),
        .core_out       (core_out),
        .core_out_ready (core_out_ready),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;

    logic [31:0] msg_w [NREQ][$];
    int          msg_pos [NREQ];
    logic [1:0]  msg_bn [NREQ];
    bit          has_msg [NREQ];

    logic [511:0] exp_q[$];
    int           own_q[$];
    int           served[$];
    int           rr_m;
    int           cur_owner;
    bit           feeding;
    bit           waiting;
    int           clr_cnt;
    int           bp_cycles;

    logic [31:0]  core_w[$];
    int           core_lat;
    logic [1:0]   core_bn_m;

    int           stall_cnt;
    int           stall_at;
    bit           rand_bp;
    bit           owner_drop;
    bit           toggle1;
    logic [1:0]   last_bn_seen;
    logic         last_flag_seen;

    // Stand-in for Keccak-512: order-sensitive fingerprint of the absorbed words.
    function automatic logic [511:0] fp(input logic [31:0] w[$], input logic [1:0] bn);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < w.size(); i++) begin
            d = {d[504:0], d[511:505]};
            d[31:0] = d[31:0] ^ w[i];
            d[511:448] = d[511:448] + 64'(w[i]) * 64'(i + 1);
        end
        d[447:440] = d[447:440] ^ {bn, 6'(w.size())};
        return d;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_all();
        for (int i = 0; i < NREQ; i++) begin
            logic v;
            logic l;
            v = 1'b0;
            l = 1'b0;
            if (has_msg[i]) begin
                v = 1'b1;
                if (owner_drop && i == cur_owner && $urandom_range(0, 3) == 0) v = 1'b0;
                if (toggle1 && i == 1 && has_msg[0]) v = 1'($urandom_range(0, 1));
                l = (msg_pos[i] == msg_w[i].size() - 1);
                req_data[32*i +: 32]   = msg_w[i][msg_pos[i]];
                req_byte_num[2*i +: 2] = l ? msg_bn[i] : 2'd0;
            end else begin
                req_data[32*i +: 32]   = '0;
                req_byte_num[2*i +: 2] = '0;
            end
            req_valid[i] = v;
            req_last[i]  = l;
        end
        if (stall_cnt > 0) begin
            core_buf_full = 1'b1;
            stall_cnt--;
        end else begin
            core_buf_full = rand_bp && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic load(input int r, input logic [31:0] w[$], input logic [1:0] bn);
        msg_w[r]   = w;
        msg_pos[r] = 0;
        msg_bn[r]  = bn;
        has_msg[r] = 1'b1;
        drive_all();
    endtask

    task automatic load_random(input int r, input int len);
        logic [31:0] w[$];
        for (int k = 0; k < len; k++) w.push_back($urandom);
        load(r, w, 2'($urandom_range(0, 3)));
    endtask

    // One clock: check outputs at the falling edge, then advance models after the rising edge.
    task automatic step();
        int   g;
        bit   acc;
        bit   take;
        bit   do_rst;
        logic [31:0] t_data;
        logic t_last;
        logic [1:0] t_bn;
        acc = 1'b0;
        @(negedge clk);
        if (cur_owner < 0 && grant != '0) begin
            int e;
            e = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (e < 0 && has_msg[(rr_m + k) % NREQ]) e = (rr_m + k) % NREQ;
            end
            check("grant_owner", 512'(grant), (e < 0) ? 512'(0) : 512'(1 << e));
            if (e >= 0) begin
                cur_owner = e;
                exp_q.push_back(fp(msg_w[e], msg_bn[e]));
                own_q.push_back(e);
                clr_cnt = 0;
                feeding = 1'b0;
                waiting = 1'b0;
            end
        end
        g = cur_owner;
        if (grant == '0) begin
            check("idle_req_ready", 512'(req_ready), 512'(0));
            check("idle_core_if", {core_in, core_in_ready, core_is_last, core_byte_num}, 512'(0));
        end else begin
            check("ready_subset", 512'(req_ready & ~grant), 512'(0));
        end
        if (core_buf_full) begin
            bp_cycles++;
            check("bp_ready", 512'(req_ready), 512'(0));
        end
        if (g >= 0 && !feeding && !waiting) begin
            if (core_reset) clr_cnt++;
            else feeding = 1'b1;
        end
        if (g >= 0 && feeding) begin
            check("fwd_in_ready", 512'(core_in_ready), 512'(req_valid[g] && !core_buf_full));
            if (req_valid[g]) begin
                logic l;
                l = (msg_pos[g] == msg_w[g].size() - 1);
                check("fwd_word", {core_in, core_is_last, core_byte_num},
                      {msg_w[g][msg_pos[g]], l, l ? msg_bn[g] : 2'd0});
            end
            acc = req_valid[g] && req_ready[g];
            if (acc && msg_pos[g] == msg_w[g].size() - 1) begin
                last_bn_seen   = core_byte_num;
                last_flag_seen = core_is_last;
            end
        end else if (g >= 0 && waiting) begin
            check("wait_in_ready", 512'(core_in_ready), 512'(0));
        end
        if (done != '0) begin
            if (own_q.size() > 0 && waiting) begin
                int e;
                e = own_q.pop_front();
                check("done_onehot", 512'(done), 512'(1 << e));
                check("digest", digest, exp_q.pop_front());
                served.push_back(e);
                rr_m = (e + 1) % NREQ;
                cur_owner = -1;
                waiting = 1'b0;
            end else begin
                check("done_spurious", 512'(done), 512'(0));
            end
        end
        take   = core_in_ready && !core_buf_full;
        t_data = core_in;
        t_last = core_is_last;
        t_bn   = core_byte_num;
        do_rst = core_reset;

        @(posedge clk);
        #1;
        if (do_rst) begin
            core_w.delete();
            core_lat = 0;
            core_out_ready = 1'b0;
        end else begin
            if (core_lat > 0) begin
                core_lat--;
                if (core_lat == 0) begin
                    core_out = fp(core_w, core_bn_m);
                    core_out_ready = 1'b1;
                end
            end
            if (take) begin
                core_w.push_back(t_data);
                if (t_last) begin
                    core_bn_m = t_bn;
                    core_lat = 3;
                end
            end
        end
        if (acc) begin
            if (msg_pos[g] == 0) check("clear_pulse", 512'(clr_cnt), 512'(1));
            msg_pos[g]++;
            if (msg_pos[g] == msg_w[g].size()) begin
                has_msg[g] = 1'b0;
                feeding = 1'b0;
                waiting = 1'b1;
            end
        end
        if (stall_at >= 0 && g >= 0 && has_msg[g] && msg_pos[g] == stall_at) begin
            stall_cnt = 10;
            stall_at = -1;
        end
        drive_all();
    endtask

    task automatic run_until_idle(input int limit);
        int c;
        bit pend;
        c = 0;
        pend = 1'b1;
        while (pend && c < limit) begin
            step();
            c++;
            pend = (own_q.size() > 0) || (cur_owner >= 0);
            for (int i = 0; i < NREQ; i++) if (has_msg[i]) pend = 1'b1;
        end
        tests_run++;
        assert (c < limit) else begin
            tests_failed++;
            $error("FAIL timeout observed=%0d cycles expected<%0d", c, limit);
        end
        repeat (3) step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            has_msg[i] = 1'b0;
            msg_pos[i] = 0;
        end
        exp_q.delete();
        own_q.delete();
        rr_m = 0;
        cur_owner = -1;
        feeding = 1'b0;
        waiting = 1'b0;
        core_w.delete();
        core_lat = 0;
        core_out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] w[$];
        string s;
        int c;

        reset_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; req_byte_num = '0;
        core_buf_full = 1'b0; core_out = '0; core_out_ready = 1'b0;
        stall_cnt = 0; stall_at = -1; rand_bp = 1'b0; owner_drop = 1'b0; toggle1 = 1'b0;
        bp_cycles = 0; core_bn_m = '0; clr_cnt = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 512'(grant), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_digest", digest, 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_core_reset", 512'(core_reset), 512'(1));
        check("rst_in_ready", 512'(core_in_ready), 512'(0));
        check("rst_state", 512'(dbg_state), 512'(0));
        reset_n = 1'b1;

        // Simultaneous requests straight after reset, two rounds.
        for (int round = 0; round < 2; round++) begin
            served.delete();
            load_random(0, 5);
            load_random(1, 7);
            run_until_idle(400);
            check("rr_order_len", 512'(served.size()), 512'(2));
            if (served.size() == 2) begin
                check("rr_first", 512'(served[0]), 512'(0));
                check("rr_second", 512'(served[1]), 512'(1));
            end
        end

        // "Hello, world!" from requester 0 alone.
        served.delete();
        w.delete();
        w.push_back("Hell"); w.push_back("o, w"); w.push_back("orld"); w.push_back("!   ");
        load(0, w, 2'd1);
        run_until_idle(200);
        check("hello_served", 512'(served.size()), 512'(1));

        // 17-word message with a 10-cycle core stall after word 5.
        bp_cycles = 0;
        stall_at = 5;
        load_random(0, 17);
        run_until_idle(400);
        check("stall_cycles", 512'(bp_cycles), 512'(10));

        // Empty final word carrying byte_num=0.
        s = "The quick brown fox jumps over the lazy dog.";
        w.delete();
        for (int k = 0; k < 11; k++) w.push_back({s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]});
        w.push_back(32'h0);
        load(0, w, 2'd0);
        run_until_idle(300);
        check("empty_last_bn", 512'(last_bn_seen), 512'(0));
        check("empty_last_flag", 512'(last_flag_seen), 512'(1));

        // Asynchronous reset while requester 1 is mid-message.
        load_random(1, 12);
        c = 0;
        while (!(cur_owner == 1 && feeding && msg_pos[1] >= 3) && c < 100) begin
            step();
            c++;
        end
        check("abort_reached", 512'(c < 100), 512'(1));
        reset_n = 1'b0;
        #1;
        check("abort_grant", 512'(grant), 512'(0));
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_core_reset", 512'(core_reset), 512'(1));
        check("abort_done", 512'(done), 512'(0));
        check("abort_digest", digest, 512'(0));
        model_reset();
        drive_all();
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_hold_reset", 512'(core_reset), 512'(1));
        end
        reset_n = 1'b1;
        served.delete();
        load_random(1, 6);
        run_until_idle(300);
        check("after_abort_owner", 512'((served.size() == 1) ? served[0] : -1), 512'(1));

        // Requester 1 toggles valid while requester 0 owns the core.
        served.delete();
        toggle1 = 1'b1;
        load_random(0, 9);
        load_random(1, 4);
        run_until_idle(400);
        toggle1 = 1'b0;
        check("toggle_count", 512'(served.size()), 512'(2));
        if (served.size() == 2) begin
            check("toggle_first", 512'(served[0]), 512'(0));
            check("toggle_next", 512'(served[1]), 512'(1));
        end

        // Random rounds: random subsets, lengths, owner valid gaps and backpressure.
        rand_bp = 1'b1;
        owner_drop = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int pick;
            pick = $urandom_range(1, 3);
            for (int i = 0; i < NREQ; i++) begin
                if (pick[i]) load_random(i, $urandom_range(1, 12));
            end
            run_until_idle(1500);
        end
        rand_bp = 1'b0;
        owner_drop = 1'b0;
        check("scoreboard_empty", 512'(exp_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
